// File: rtl/melody_player.sv
// Melody sequencer: walks a song score in an external synchronous ROM
// and drives a square-wave buzzer with tempo, articulation gap and pause.
`timescale 1ns/1ps
module melody_player #(
   parameter int unsigned TEMPO_TICKS = 12_000_000,
   parameter int unsigned GAP_TICKS   = 1_200_000,
   parameter int unsigned PERIOD_W    = 16,
   parameter int unsigned DUR_W       = 4,
   parameter int unsigned NOTE_AW     = 5,
   parameter int unsigned SONG_W      = 2
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        play,
   input  logic                        stop,
   input  logic                        sel,
   input  logic                        loop,
   input  logic [SONG_W-1:0]           song,
   output logic [SONG_W+NOTE_AW-1:0]   rom_addr,
   input  logic [PERIOD_W+DUR_W-1:0]   rom_data,
   output logic                        buzzer,
   output logic                        playing,
   output logic                        paused
);

   localparam int unsigned MAX_LEN = (2**DUR_W - 1) * TEMPO_TICKS;
   localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_PLAY,
      S_PAUSE
   } state_t;

   state_t              state_q, state_d;
   logic                play_q, play_d;
   logic [SONG_W-1:0]   song_q, song_d;
   logic [NOTE_AW-1:0]  note_idx_q, note_idx_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic [CNT_W-1:0]    dur_cnt_q, dur_cnt_d;
   logic [PERIOD_W-1:0] tone_q, tone_d;
   logic                phase_q, phase_d;
   logic                buzzer_q, buzzer_d;
   logic                playing_q, playing_d;
   logic                paused_q, paused_d;

   logic                rise;
   logic                song_end;
   logic                wrap;
   logic [PERIOD_W-1:0] rom_period;
   logic [DUR_W-1:0]    rom_dur;

   assign rise       = play & ~play_q;
   assign rom_period = rom_data[PERIOD_W+DUR_W-1:DUR_W];
   assign rom_dur    = rom_data[DUR_W-1:0];
   assign wrap       = (tone_q == period_q - PERIOD_W'(1));

   always_comb begin
      state_d    = state_q;
      play_d     = play;
      song_d     = song_q;
      note_idx_d = note_idx_q;
      period_d   = period_q;
      len_d      = len_q;
      dur_cnt_d  = dur_cnt_q;
      tone_d     = tone_q;
      phase_d    = phase_q;
      song_end   = 1'b0;
      if (stop) begin
         state_d    = S_IDLE;
         note_idx_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (rise && sel) begin
                  song_d  = song;
                  state_d = S_FETCH;
               end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
               period_d  = rom_period;
               len_d     = CNT_W'(rom_dur) * CNT_W'(TEMPO_TICKS);
               dur_cnt_d = '0;
               tone_d    = '0;
               phase_d   = 1'b0;
               if (rom_dur != '0) state_d = S_PLAY;
               else song_end = 1'b1;
            end
            S_PLAY: begin
               if (dur_cnt_q == len_q - CNT_W'(1)) begin
                  if (&note_idx_q) begin
                     song_end = 1'b1;
                  end else begin
                     note_idx_d = note_idx_q + NOTE_AW'(1);
                     state_d    = S_FETCH;
                  end
               end else begin
                  dur_cnt_d = dur_cnt_q + CNT_W'(1);
                  tone_d    = wrap ? '0 : tone_q + PERIOD_W'(1);
                  phase_d   = wrap ? ~phase_q : phase_q;
                  if (rise) state_d = S_PAUSE;
               end
            end
            S_PAUSE: begin
               // resume keeps counts but restarts the waveform low
               if (rise) begin
                  phase_d = 1'b0;
                  state_d = S_PLAY;
               end
            end
            default: state_d = S_IDLE;
         endcase
         if (song_end) begin
            note_idx_d = '0;
            state_d    = loop ? S_FETCH : S_IDLE;
         end
      end
      buzzer_d  = (state_d == S_PLAY) && phase_d &&
                  (period_d != '0) &&
                  (dur_cnt_d < len_d - CNT_W'(GAP_TICKS));
      playing_d = (state_d == S_FETCH) || (state_d == S_LOAD) ||
                  (state_d == S_PLAY);
      paused_d  = (state_d == S_PAUSE);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         play_q     <= 1'b0;
         song_q     <= '0;
         note_idx_q <= '0;
         period_q   <= '0;
         len_q      <= '0;
         dur_cnt_q  <= '0;
         tone_q     <= '0;
         phase_q    <= 1'b0;
         buzzer_q   <= 1'b0;
         playing_q  <= 1'b0;
         paused_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         play_q     <= play_d;
         song_q     <= song_d;
         note_idx_q <= note_idx_d;
         period_q   <= period_d;
         len_q      <= len_d;
         dur_cnt_q  <= dur_cnt_d;
         tone_q     <= tone_d;
         phase_q    <= phase_d;
         buzzer_q   <= buzzer_d;
         playing_q  <= playing_d;
         paused_q   <= paused_d;
      end
   end

   assign rom_addr = {song_q, note_idx_q};
   assign buzzer   = buzzer_q;
   assign playing  = playing_q;
   assign paused   = paused_q;

endmodule

// File: doc/melody_player.md
# melody_player

Parametrised melody sequencer. It steps through a note score held in an external synchronous ROM and drives a square-wave buzzer. It supports multiple songs, pause/resume, loop mode and a configurable tempo and articulation gap. It sits between the board push-buttons/switches and the buzzer pin, and it replaces the fixed single-song timer/divider/controller chain with one configurable block.

## Interface
- `TEMPO_TICKS`, default 12_000_000: clock cycles per duration unit; must be ≥ 2.
- `GAP_TICKS`, default 1_200_000: silent cycles at the end of every note; must be < `TEMPO_TICKS`.
- `PERIOD_W`, default 16: width of the half-period field.
- `DUR_W`, default 4: width of the duration field, in units.
- `NOTE_AW`, default 5: note-index width; each song has `2**NOTE_AW` slots.
- `SONG_W`, default 2: song-select width.
- `clock` input, 1 bit: the single clock; all logic is on its rising edge.
- `reset_n` input, 1 bit: synchronous, active-low reset.
- `play` input, 1 bit: level button; only its rising edge is used.
- `stop` input, 1 bit: level; has priority over `play`.
- `sel` input, 1 bit: enable; `play` is ignored in IDLE while `sel`=0.
- `loop` input, 1 bit: sampled at end of song; 1 restarts the song at note 0.
- `song` input, `SONG_W` bits: song number, latched when playback starts.
- `rom_addr` output, `SONG_W+NOTE_AW` bits: {song_latched, note_idx}.
- `rom_data` input, `PERIOD_W+DUR_W` bits: {period, dur}; valid one cycle after `rom_addr`.
- `buzzer` output, 1 bit: square-wave tone.
- `playing` output, 1 bit: high in FETCH, LOAD and PLAY.
- `paused` output, 1 bit: high in PAUSE.

## Operation
- Edge detect: `play_q` holds the registered `play`. `rise = play & ~play_q`, evaluated in the same cycle.
- IDLE: `buzzer`=0 and `note_idx`=0. On `rise & sel & ~stop`, the block latches `song` and goes to FETCH.
- FETCH (1 cycle): `rom_addr` presents the current note. Next state is LOAD.
- LOAD (1 cycle): captures `period` and `dur` from `rom_data`.
  - If `dur`≠0, go to PLAY with the tone counter = 0, duration counter = 0, and `buzzer`=0.
  - If `dur`=0, the song has ended (see end-of-song rule).
- PLAY: the note lasts exactly `dur*TEMPO_TICKS` cycles.
  - The tone counter counts 0..`period`-1. `buzzer` toggles when it wraps.
  - If `period`=0, the note is a rest and `buzzer` is held at 0.
  - During the last `GAP_TICKS` cycles of the note, `buzzer` is forced to 0 and the tone counter keeps running.
  - At note end, `note_idx` increments and the block goes to FETCH.
  - If `note_idx` was `2**NOTE_AW-1`, the song has ended instead.
- End of song:
  - If `loop`=1, `note_idx` becomes 0 and the block goes to FETCH.
  - Otherwise the block goes to IDLE.
- PAUSE:
  - Entered from PLAY on `rise`. All counters and `note_idx` are frozen and `buzzer`=0.
  - On `rise`, return to PLAY and continue the note from the frozen counts. The buzzer phase restarts at 0.
  - A `rise` in FETCH or LOAD is ignored.
- `stop`=1 in any state: next state is IDLE, `note_idx`=0 and `buzzer`=0. It wins over a simultaneous `rise`.
- `sel` only gates the start from IDLE. Lowering it mid-song has no effect.
- Changing `song` mid-song has no effect until the next start from IDLE.

## Timing
- Reset (`reset_n`=0 at an edge):
  - State is IDLE.
  - `buzzer`, `playing`, `paused`, `play_q` and `note_idx` are all 0.
  - `rom_addr` is 0.
  - Reset mid-note aborts playback immediately; there is no fade-out.
- Start latency: with `rise` sampled at edge 0:
  - FETCH occupies cycle 1 and LOAD occupies cycle 2.
  - The first PLAY cycle is cycle 3.
  - The first `buzzer` rise comes `period` cycles into PLAY.
- Inter-note overhead: exactly 2 silent cycles (FETCH and LOAD) between notes.
- Outputs are registered, with no combinational path from the inputs to `buzzer`, `playing` or `paused`.
- Counter widths:
  - The duration counter covers `(2**DUR_W-1)*TEMPO_TICKS` without overflow.
  - The tone counter is `PERIOD_W` bits wide.

## Test plan
Bench parameters: `TEMPO_TICKS`=4, `GAP_TICKS`=1, `PERIOD_W`=8, `DUR_W`=4, `NOTE_AW`=2, `SONG_W`=1.

1. **Basic playback.** Song 0 is {(2,3),(0,1),(1,2),(0,0)}, `loop`=0.
   - Pulse `play` with `sel`=1.
   - `rom_addr` = 0 in cycle 1.
   - Note 0 lasts 12 PLAY cycles; `buzzer` toggles every 2 cycles and is 0 in the last cycle.
   - Note 1 is silent for 4 cycles.
   - Note 2 toggles every cycle for 8 cycles.
   - The block then returns to IDLE with `playing`=0.
2. **Loop and index wrap.** Song 1 is all four slots with `dur`=1, `loop`=1.
   - After slot 3, `rom_addr` goes to 4 (song 1, note 0) and playback continues.
   - With `loop`=0 at wrap, the block goes to IDLE.
3. **Pause/resume.**
   - Pulse `play` 5 cycles into note 0: `paused`=1 and `buzzer`=0 indefinitely.
   - A second pulse resumes; note 0 ends after 7 more PLAY cycles.
4. **Stop priority.**
   - Assert `stop` and `play` rise in the same cycle mid-note: next state is IDLE, `note_idx`=0, `buzzer`=0.
   - A later start begins again at note 0.
5. **Start gating.**
   - Pulse `play` with `sel`=0 in IDLE: nothing happens.
   - Hold `play` high for 20 cycles: exactly one start.
   - Change `song` mid-song: `rom_addr` MSB is unchanged.
6. **Reset mid-note.** Drive `reset_n`=0 for one edge during PLAY: all outputs are 0 on the next cycle and the state is IDLE.
